// File: rtl/block_buffer_pp_if.sv
// Write-side and read-side handshake bundle for the ping-pong block buffer.
// The master is the pixel source and consumer pair. The slave is the buffer.
interface block_buffer_pp_if #(
   parameter int W    = 8,
   parameter int BLK  = 4,
   parameter int LOGN = 4
);
   logic                  WR;
   logic [LOGN-1:0]       ADDR_W;
   logic [W-1:0]          DATA_W;
   logic                  AUTO;
   logic                  LAST;
   logic                  WR_READY;
   logic                  OUT_VALID;
   logic                  OUT_READY;
   logic [W*BLK*BLK-1:0]  data_out;

   modport master (
      output WR, ADDR_W, DATA_W, AUTO, LAST, OUT_READY,
      input  WR_READY, OUT_VALID, data_out
   );

   modport slave (
      input  WR, ADDR_W, DATA_W, AUTO, LAST, OUT_READY,
      output WR_READY, OUT_VALID, data_out
   );
endinterface

// File: rtl/block_buffer_pp.sv
// Ping-pong buffer of two BLK x BLK pixel banks. One bank is filled by the
// upstream source while the other is presented flat to the transform stage.
module block_buffer_pp #(
   parameter int W    = 8,
   parameter int BLK  = 4,
   parameter int LOGN = 4
) (
   input logic              CLK,
   input logic              RST,
   block_buffer_pp_if.slave bus
);
   localparam int N = BLK * BLK;
   localparam logic [LOGN:0] N_C        = (LOGN+1)'(N);
   localparam logic [LOGN:0] LAST_IDX_C = (LOGN+1)'(N - 1);

   logic [W-1:0]  bank_r [2][N];
   logic [1:0]    full_r;
   logic          wr_sel_r;
   logic          rd_sel_r;
   logic [LOGN:0] wr_cnt_r;

   logic          accept_s;
   logic          commit_s;
   logic          release_s;
   logic [LOGN:0] addr_s;
   logic [LOGN:0] cnt_inc_s;

   // Handshake decode. The address carries an extra bit so a counter value of N cannot alias element 0.
   always_comb begin
      accept_s = bus.WR && !full_r[wr_sel_r];
      if (bus.AUTO) begin
         addr_s = wr_cnt_r;
      end else begin
         addr_s = {1'b0, bus.ADDR_W};
      end
      if (wr_cnt_r == N_C) begin
         cnt_inc_s = N_C;
      end else begin
         cnt_inc_s = wr_cnt_r + (LOGN+1)'(1);
      end
      commit_s  = accept_s && (bus.LAST || (bus.AUTO && (wr_cnt_r == LAST_IDX_C)));
      release_s = full_r[rd_sel_r] && bus.OUT_READY;
   end

   // Bank occupancy, pointer and write-count state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         full_r   <= 2'b00;
         wr_sel_r <= 1'b0;
         rd_sel_r <= 1'b0;
         wr_cnt_r <= {(LOGN+1){1'b0}};
      end else begin
         if (commit_s) begin
            full_r[wr_sel_r] <= 1'b1;
            wr_sel_r         <= ~wr_sel_r;
            wr_cnt_r         <= {(LOGN+1){1'b0}};
         end else if (accept_s) begin
            wr_cnt_r <= cnt_inc_s;
         end
         // A commit needs an empty write bank and a release needs a full read bank, so both can act in one cycle.
         if (release_s) begin
            full_r[rd_sel_r] <= 1'b0;
            rd_sel_r         <= ~rd_sel_r;
         end
      end
   end

   // Pixel storage. Out-of-range addresses match no element, which discards the data.
   always_ff @(posedge CLK) begin
      for (int b = 0; b < 2; b++) begin
         for (int e = 0; e < N; e++) begin
            if (RST) begin
               bank_r[b][e] <= {W{1'b0}};
            end else if (accept_s && (wr_sel_r == b[0]) && (addr_s == (LOGN+1)'(e))) begin
               bank_r[b][e] <= bus.DATA_W;
            end
         end
      end
   end

   // Read-bank flattening. Element 0 is placed in the MSBs.
   always_comb begin
      bus.data_out = {(W*N){1'b0}};
      for (int e = 0; e < N; e++) begin
         bus.data_out[(N-1-e)*W +: W] = bank_r[rd_sel_r][e];
      end
   end

   assign bus.WR_READY  = !full_r[wr_sel_r];
   assign bus.OUT_VALID = full_r[rd_sel_r];
endmodule

// File: tb/tb_block_buffer_pp.sv
// Directed self-checking bench for block_buffer_pp with the 8-bit 4x4 configuration.
module tb_block_buffer_pp;
   localparam int W = 8, BLK = 4, LOGN = 4, N = 16;

   logic CLK = 1'b0;
   logic RST;
   int   checks   = 0;
   int   failures = 0;
   logic [127:0] exp_v;
   logic [127:0] hold_v;

   always #5 CLK = ~CLK;

   block_buffer_pp_if #(.W(W), .BLK(BLK), .LOGN(LOGN)) bus ();

   block_buffer_pp #(.W(W), .BLK(BLK), .LOGN(LOGN)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic auto_m, input logic [3:0] a, input logic [7:0] d, input logic last);
      bus.WR     = 1'b1;
      bus.AUTO   = auto_m;
      bus.ADDR_W = a;
      bus.DATA_W = d;
      bus.LAST   = last;
      cyc();
   endtask

   function automatic logic [127:0] seq(input logic [7:0] s);
      logic [127:0] v;
      v = 128'd0;
      for (int i = 0; i < N; i++) v[(N-1-i)*8 +: 8] = s + 8'(i);
      return v;
   endfunction

   initial begin
      // Reset with a write request pending.
      RST = 1'b1;
      bus.WR = 1'b1; bus.AUTO = 1'b1; bus.ADDR_W = 4'd0; bus.DATA_W = 8'h55;
      bus.LAST = 1'b0; bus.OUT_READY = 1'b0;
      cyc(); cyc();
      chk("rst_out_valid", bus.OUT_VALID, 128'd0);
      chk("rst_wr_ready", bus.WR_READY, 128'd1);
      chk("rst_data", bus.data_out, 128'd0);
      RST = 1'b0; bus.WR = 1'b0;
      cyc();
      chk("post_rst_data", bus.data_out, 128'd0);

      // Auto fill of bank 0 with 1..16.
      for (int i = 1; i <= 16; i++) begin
         wr(1'b1, 4'd0, 8'(i), 1'b0);
         if (i == 15) chk("fill_not_yet_valid", bus.OUT_VALID, 128'd0);
      end
      bus.WR = 1'b0;
      chk("fill_valid", bus.OUT_VALID, 128'd1);
      chk("fill_data", bus.data_out, seq(8'h01));
      chk("fill_wr_ready", bus.WR_READY, 128'd1);

      // Second block fills bank 1. Both banks are then full and further writes stall.
      for (int i = 17; i <= 32; i++) wr(1'b1, 4'd0, 8'(i), 1'b0);
      chk("stall_wr_ready", bus.WR_READY, 128'd0);
      chk("stall_data_hold", bus.data_out, seq(8'h01));
      for (int i = 0; i < 3; i++) wr(1'b1, 4'd0, 8'hEE, 1'b0);
      chk("stall_ignored_ready", bus.WR_READY, 128'd0);
      chk("stall_ignored_data", bus.data_out, seq(8'h01));
      bus.WR = 1'b0; bus.OUT_READY = 1'b1;
      cyc();
      bus.OUT_READY = 1'b0;
      chk("swap_data", bus.data_out, seq(8'h11));
      chk("swap_valid", bus.OUT_VALID, 128'd1);
      chk("swap_wr_ready", bus.WR_READY, 128'd1);

      // Concurrent commit of bank 0 and release of bank 1.
      for (int i = 0; i < 15; i++) wr(1'b1, 4'd0, 8'h40 + 8'(i), 1'b0);
      chk("conc_pre_data", bus.data_out, seq(8'h11));
      bus.OUT_READY = 1'b1;
      wr(1'b1, 4'd0, 8'h4F, 1'b0);
      bus.OUT_READY = 1'b0; bus.WR = 1'b0;
      chk("conc_valid", bus.OUT_VALID, 128'd1);
      chk("conc_data", bus.data_out, seq(8'h40));
      chk("conc_wr_ready", bus.WR_READY, 128'd1);

      // A reset after seven writes restarts the count and clears both banks.
      for (int i = 0; i < 7; i++) wr(1'b1, 4'd0, 8'h70 + 8'(i), 1'b0);
      RST = 1'b1; bus.DATA_W = 8'h77;
      cyc();
      RST = 1'b0;
      chk("mid_rst_valid", bus.OUT_VALID, 128'd0);
      chk("mid_rst_ready", bus.WR_READY, 128'd1);
      chk("mid_rst_data", bus.data_out, 128'd0);
      for (int i = 0; i < 16; i++) begin
         wr(1'b1, 4'd0, 8'h80 + 8'(i), 1'b0);
         if (i == 8)  chk("fresh_no_early_commit", bus.OUT_VALID, 128'd0);
         if (i == 14) chk("fresh_not_yet_valid", bus.OUT_VALID, 128'd0);
      end
      bus.WR = 1'b0;
      chk("fresh_valid", bus.OUT_VALID, 128'd1);
      chk("fresh_data", bus.data_out, seq(8'h80));
      bus.OUT_READY = 1'b1;
      cyc();
      bus.OUT_READY = 1'b0;
      chk("fresh_release", bus.OUT_VALID, 128'd0);

      // Addressed partial block into the cleared bank 1.
      wr(1'b0, 4'd5, 8'hAA, 1'b0);
      chk("addr_no_commit", bus.OUT_VALID, 128'd0);
      wr(1'b0, 4'd15, 8'hBB, 1'b1);
      bus.WR = 1'b0; bus.LAST = 1'b0;
      exp_v = 128'd0;
      exp_v[(N-1-5)*8 +: 8] = 8'hAA;
      exp_v[7:0] = 8'hBB;
      chk("addr_valid", bus.OUT_VALID, 128'd1);
      chk("addr_data", bus.data_out, exp_v);

      // In addressed mode seventeen writes without LAST do not commit.
      for (int i = 0; i < 17; i++) wr(1'b0, 4'(i % 16), 8'hC0, 1'b0);
      bus.WR = 1'b0;
      chk("sat_wr_ready", bus.WR_READY, 128'd1);
      chk("sat_data_hold", bus.data_out, exp_v);
      bus.OUT_READY = 1'b1;
      wr(1'b0, 4'd0, 8'hD0, 1'b1);
      bus.OUT_READY = 1'b0; bus.WR = 1'b0; bus.LAST = 1'b0;
      hold_v = {16{8'hC0}};
      hold_v[127:120] = 8'hD0;
      chk("sat_commit_valid", bus.OUT_VALID, 128'd1);
      chk("sat_commit_data", bus.data_out, hold_v);
      bus.OUT_READY = 1'b1;
      cyc();
      bus.OUT_READY = 1'b0;
      chk("final_release", bus.OUT_VALID, 128'd0);
      chk("final_wr_ready", bus.WR_READY, 128'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/block_buffer_pp.md
# block_buffer_pp

Parametrised ping-pong block buffer, the successor to the fixed 4x4 single-bank pixel register file in the compression datapath. It holds two banks of BLK x BLK pixels. The upstream pixel source fills one bank, by explicit address or in raster auto-increment mode, while the transform stage reads the other bank as one flattened word. Banks swap under a valid/ready handshake, so block N+1 loads while block N is being consumed.

## Interface
- W, 8, pixel width in bits
- BLK, 4, block side length; N = BLK*BLK elements per bank
- LOGN, 4, address width; must satisfy 2^LOGN >= N
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous, active-high reset
- WR  input  1  write request
- ADDR_W  input  LOGN  element address, used when AUTO=0
- DATA_W  input  W  pixel data
- AUTO  input  1  1 = address from internal counter (raster order), 0 = ADDR_W
- LAST  input  1  with an accepted write, marks the final element of the block
- WR_READY  output  1  write bank can accept data
- OUT_VALID  output  1  read bank holds a complete block
- OUT_READY  input  1  consumer releases the read bank
- data_out  output  W*N  read-bank contents; element 0 in the MSBs, element N-1 in the LSBs

## Operation
- Storage: two banks of N x W registers, plus full[1:0], wr_sel, rd_sel and wr_cnt (LOGN+1 bits).
- WR_READY = !full[wr_sel].
- OUT_VALID = full[rd_sel].
- data_out = bank[rd_sel], driven combinationally from registers.
- Write accept = WR && WR_READY. When WR_READY=0, WR is ignored: no storage change, no count.
- Write address: AUTO ? wr_cnt : ADDR_W. AUTO is sampled on each accepted write.
- An address >= N (possible when N is not a power of two) discards the data. The write still counts and may still commit.
- Each accepted write increments wr_cnt.
- Commit = accept && (LAST || (AUTO && wr_cnt == N-1)). On commit: full[wr_sel] <= 1, wr_sel toggles, wr_cnt <= 0. Data written in the commit cycle lands in the committing bank.
- Release = OUT_VALID && OUT_READY. On release: full[rd_sel] <= 0, rd_sel toggles.
- Bank contents are never cleared except by RST. Elements not written in a block retain the previous contents of that bank.
- In addressed mode, wr_cnt saturates at N. It does not wrap, and commit requires LAST.
- Commit and release in the same cycle always target different banks. Both take effect.
- Per-bank states: EMPTY -> (commit) FULL -> (release) EMPTY. The pointers alternate strictly: 0,1,0,1,...

## Timing
- Reset values:
  - storage all 0, full = 00, wr_sel = rd_sel = 0, wr_cnt = 0
  - outputs: WR_READY = 1, OUT_VALID = 0, data_out = 0
- RST has priority over every other input in the same cycle. Asserting it mid-block discards partial and full banks.
- A write accepted at edge k is visible in storage after edge k.
- A commit at edge k raises OUT_VALID in cycle k+1 if that bank is the read bank. data_out is stable from the same cycle.
- A release at edge k lowers OUT_VALID in cycle k+1, or presents the other bank if it is already full.
- With both banks full, WR_READY = 0. A release at edge k restores WR_READY in cycle k+1. There is no combinational path from OUT_READY to WR_READY.
- Sustained throughput: one pixel per cycle with no bubbles, provided the consumer releases within N cycles.
- data_out must not change while OUT_VALID=1 and no release has occurred.

## Test plan
- Reset: assert RST for 2 cycles with WR=1 -> OUT_VALID=0, WR_READY=1, data_out=0, no write lands.
- Auto fill: AUTO=1, write values 1..16 on 16 consecutive cycles, LAST=0, OUT_READY=0 -> OUT_VALID=1 in the cycle after the 16th write; data_out = 0x0102...0F10, MSB byte = 1.
- Ping-pong stall: OUT_READY=0, auto-fill two blocks (1..16, then 17..32), then hold WR=1 -> WR_READY=0 after the second commit, third-block data ignored. Pulse OUT_READY once -> data_out shows 17..32 next cycle and WR_READY=1.
- Addressed partial block: AUTO=0, write 0xAA to address 5 and 0xBB to address 15 with LAST=1 -> block commits. Only bytes 5 and 15 are nonzero; data_out[7:0] = 0xBB.
- Concurrent: with bank 0 full and bank 1 on its final write, assert OUT_READY in the commit cycle -> next cycle OUT_VALID=1 showing bank 1, WR_READY=1, bank 0 writable.
- Mid-block reset: after 7 auto writes, assert RST -> wr_cnt=0. The next 16 writes form a fresh block and commit on the 16th.
